// File: rtl/patram_arb_pkg.sv
// Shared types and constants for the Pattern-RAM read arbiter.
// Optional sprite-priority mode is selected by PATRAM_ARB_SPRITE_PRIO_EN.
package patram_arb_pkg;

   localparam int PATRAM_ADDR_W = 12;
   localparam int PATRAM_DATA_W = 64;
   localparam int NUM_REQ_MAX   = 4;
   localparam int ARB_ID_W      = $clog2(NUM_REQ_MAX);

   typedef logic [PATRAM_ADDR_W-1:0] patram_addr_t;
   typedef logic [PATRAM_DATA_W-1:0] patram_word_t;
   typedef logic [ARB_ID_W-1:0]      arb_id_t;

   // One slot of the return pipeline: a read in flight and who issued it.
   typedef struct packed {
      logic    valid;
      arb_id_t id;
   } ret_slot_t;

   // Round-robin successor of requester w among n requesters.
   function automatic arb_id_t next_ptr(input arb_id_t w, input int n);
      return arb_id_t'((int'(w) + 1) % n);
   endfunction

endpackage

// File: rtl/patram_arbiter_rr.sv
// Combinational round-robin picker: searches req starting at ptr, wrapping
// modulo N, and returns the first asserted requester as one-hot and as an id.
module rr_arbiter
   import patram_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  arb_id_t      ptr,
   output logic [N-1:0] gnt,
   output arb_id_t      gnt_id,
   output logic         gnt_vld
);

   int idx;

   // Scan N positions from ptr; the first requester found wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch, so no path leaves a value unassigned and no latch is inferred.
      gnt     = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = arb_id_t'(idx);
         end
      end
   end

endmodule

// File: rtl/patram_arbiter.sv
// Pattern-RAM read-port arbiter: one round-robin grant per cycle, address
// mux onto the RAM pins, and a fixed-latency return pipeline that routes
// each read word back to its requester (0 = bg, 1 = fg, 2 = sprite).
// Define PATRAM_ARB_SPRITE_PRIO_EN to give the last requester absolute
// priority; the others then round-robin among themselves.
module patram_arbiter
   import patram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int RD_LATENCY = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*PATRAM_ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rvalid,
   output patram_word_t                     rdata,
   output patram_addr_t                     patram_addr,
   input  patram_word_t                     patram_rddata,
   output logic                             busy
);

   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] rr_req;
   logic [NUM_REQ-1:0] rr_gnt;
   arb_id_t            rr_id;
   logic               rr_vld;

   arb_id_t            win_id;
   logic               gnt_vld;
   arb_id_t            ptr_q, ptr_d;

   patram_addr_t       addr_q, addr_d;
   patram_word_t       rdata_q, rdata_d;
   ret_slot_t          pipe_q [RD_LATENCY];
   ret_slot_t          pipe_d [RD_LATENCY];
   logic               ret_vld;
   arb_id_t            ret_id;

   // No grants are issued while reset is held.
   assign arb_req = rst_n ? req : '0;

`ifdef PATRAM_ARB_SPRITE_PRIO_EN
   // The sprite requester is handled outside the round-robin ring.
   assign rr_req = arb_req & ~(NUM_REQ'(1) << (NUM_REQ - 1));
`else
   assign rr_req = arb_req;
`endif

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .req     (rr_req),
      .ptr     (ptr_q),
      .gnt     (rr_gnt),
      .gnt_id  (rr_id),
      .gnt_vld (rr_vld)
   );

   // Final winner selection and pointer advance.
   always_comb begin
      gnt     = rr_gnt;
      win_id  = rr_id;
      gnt_vld = rr_vld;
      ptr_d   = ptr_q;
      if (rr_vld) begin
         ptr_d = next_ptr(rr_id, NUM_REQ);
      end
`ifdef PATRAM_ARB_SPRITE_PRIO_EN
      // Sprite overrides the ring and leaves the pointer untouched.
      if (arb_req[NUM_REQ-1]) begin
         gnt     = NUM_REQ'(1) << (NUM_REQ - 1);
         win_id  = arb_id_t'(NUM_REQ - 1);
         gnt_vld = 1'b1;
         ptr_d   = ptr_q;
      end
`endif
   end

   // Address mux: follow the winner, otherwise hold the last address so
   // the RAM pins stay quiet between reads.
   always_comb begin
      addr_d = addr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            addr_d = req_addr[i*PATRAM_ADDR_W +: PATRAM_ADDR_W];
         end
      end
   end

   assign patram_addr = addr_d;

   // Return pipeline shift: a new slot enters on every grant cycle.
   always_comb begin
      pipe_d[0].valid = gnt_vld;
      pipe_d[0].id    = win_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   assign ret_vld = pipe_q[RD_LATENCY-1].valid;
   assign ret_id  = pipe_q[RD_LATENCY-1].id;

   // Route returning data to its owner; rdata holds between returns.
   always_comb begin
      rvalid  = '0;
      rdata_d = rdata_q;
      if (ret_vld) begin
         rvalid  = NUM_REQ'(1) << ret_id;
         rdata_d = patram_rddata;
      end
   end

   assign rdata = rdata_d;

   // Any valid slot means a read is still in flight.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         busy = busy | pipe_q[i].valid;
      end
   end

   // State registers: pointer, held address, held data and return pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         // NOTE: the return pipeline is reset, not just its data, because a
         // stale valid bit would produce a phantom rvalid after reset.
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, which is what makes the shift pipeline shift.
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         pipe_q  <= pipe_d;
      end
   end

endmodule

// File: tb/tb_patram_arbiter.sv
// Directed bench for patram_arbiter with a scoreboard on the return path.
// Follows PATRAM_ARB_SPRITE_PRIO_EN to select the matching expectations.
module tb_patram_arbiter;

   localparam int NREQ = 3;
   localparam int LAT  = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [11:0]       addr_tb [NREQ];
   logic [NREQ*12-1:0] req_addr;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rvalid;
   logic [63:0]       rdata;
   logic [11:0]       patram_addr;
   logic [63:0]       patram_rddata;
   logic              busy;

   typedef struct {
      int          id;
      logic [63:0] data;
   } exp_t;

   exp_t        exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [11:0] last_addr;
   logic [11:0] ram_a [LAT];

   assign req_addr = {addr_tb[2], addr_tb[1], addr_tb[0]};

   patram_arbiter #(
      .NUM_REQ    (NREQ),
      .RD_LATENCY (LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_addr      (req_addr),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .patram_addr   (patram_addr),
      .patram_rddata (patram_rddata),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pattern word stored at each RAM address.
   function automatic logic [63:0] word(input logic [11:0] a);
      return {a, 4'h9, a, 4'h6, a, 4'hC, a, 4'h3};
   endfunction

   // RAM model with a fixed read latency of LAT cycles.
   initial for (int i = 0; i < LAT; i++) ram_a[i] = '0;
   always @(posedge clk) begin
      ram_a[0] <= patram_addr;
      for (int i = 1; i < LAT; i++) ram_a[i] <= ram_a[i-1];
   end
   assign patram_rddata = word(ram_a[LAT-1]);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every return is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (rvalid !== '0) begin
         if (exp_q.size() == 0) begin
            check("rvalid_unexpected", 64'(rvalid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rvalid_id", 64'(rvalid), 64'(3'b001 << e.id));
            check("rdata", rdata, e.data);
         end
      end
   end

   // One cycle: drive req, check gnt and patram_addr, queue the expected return.
   task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg, input bit push = 1'b1);
      int id;
      req = r;
      @(negedge clk);
      check("gnt", 64'(gnt), 64'(eg));
      if (eg != '0) begin
         id = 0;
         for (int i = 0; i < NREQ; i++) if (eg[i]) id = i;
         check("patram_addr", 64'(patram_addr), 64'(addr_tb[id]));
         last_addr = addr_tb[id];
         if (push) exp_q.push_back('{id, word(addr_tb[id])});
      end else begin
         check("patram_addr_hold", 64'(patram_addr), 64'(last_addr));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, '0);
   endtask

   task automatic reset_checks();
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_patram_addr", 64'(patram_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < NREQ; i++) addr_tb[i] = '0;
      last_addr = '0;
      repeat (2) @(negedge clk);
      reset_checks();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single request from fg; pointer starts at 0.
      addr_tb[1] = 12'h1A3;
      cyc(3'b010, 3'b010);
      req = '0;
      @(negedge clk);
      check("busy_inflight", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      idle(4);
      check("busy_idle", 64'(busy), 64'd0);
      check("rdata_hold", rdata, word(12'h1A3));

`ifndef PATRAM_ARB_SPRITE_PRIO_EN
      // Pointer is 2: grant sprite at the top address so the pointer wraps to 0.
      addr_tb[2] = 12'hFFF;
      cyc(3'b100, 3'b100);

      // All three requesting: 001, 010, 100 repeating; address advances per grant.
      addr_tb[0] = 12'h0A0;
      addr_tb[1] = 12'h1B0;
      addr_tb[2] = 12'h2C0;
      for (int k = 0; k < 9; k++) begin
         cyc(3'b111, 3'b001 << (k % 3));
         addr_tb[k % 3] = addr_tb[k % 3] + 12'd1;
      end

      // Move pointer to 1, then 101 grants 100 and wraps to 001.
      addr_tb[0] = 12'h010;
      cyc(3'b001, 3'b001);
      addr_tb[0] = 12'h011;
      addr_tb[2] = 12'h3A0;
      cyc(3'b101, 3'b100);
      cyc(3'b101, 3'b001);
`else
      // Pointer is 2: bg grant moves it to 1.
      addr_tb[0] = 12'h010;
      cyc(3'b001, 3'b001);
`endif

      // Pointer is 1: fg wins, bg withdraws before ever being granted.
      addr_tb[0] = 12'h0EE;
      addr_tb[1] = 12'h123;
      cyc(3'b011, 3'b010);
      cyc(3'b000, 3'b000);

      // Back-to-back fg grants; the third grant coincides with the first return.
      for (int k = 0; k < 3; k++) begin
         addr_tb[1] = 12'h400 + 12'(k);
         cyc(3'b010, 3'b010);
      end
      idle(4);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      // Grant, then reset in the next cycle: the read must never return.
      addr_tb[0] = 12'h055;
      cyc(3'b001, 3'b001, 1'b0);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      reset_checks();
      @(posedge clk);
      @(negedge clk);
      reset_checks();
      @(posedge clk);
      #1 rst_n = 1'b1;
      last_addr = '0;
      idle(4);
      check("busy_after_reset", 64'(busy), 64'd0);

`ifdef PATRAM_ARB_SPRITE_PRIO_EN
      // Sprite always wins; then round-robin resumes from pointer 0.
      addr_tb[0] = 12'h600;
      addr_tb[1] = 12'h700;
      for (int k = 0; k < 4; k++) begin
         addr_tb[2] = 12'h800 + 12'(k);
         cyc(3'b111, 3'b100);
      end
      cyc(3'b011, 3'b001);
      addr_tb[0] = 12'h601;
      cyc(3'b011, 3'b010);
`else
      // After reset the pointer is 0 again.
      addr_tb[0] = 12'h600;
      addr_tb[1] = 12'h700;
      addr_tb[2] = 12'h800;
      cyc(3'b111, 3'b001);
      cyc(3'b110, 3'b010);
      cyc(3'b100, 3'b100);
`endif
      idle(4);
      check("final_drained", 64'(exp_q.size()), 64'd0);
      check("final_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
